mm_host: RTL and testbench

MM_HOST -- requirements
Module: mm_host

---
 rtl/mm_host_pkg.sv | 10 +
 rtl/mm_host_buf.sv | 18 +
 rtl/mm_host.sv | 88 ++++++++
 tb/tb_mm_host.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mm_host_pkg.sv
// mm_host_pkg: state encoding and operand/result count helpers for the matrix-multiply host.
package mm_host_pkg;
  typedef enum logic [2:0] {LOAD, START, SEND, WAIT, CAPT, DRAIN} state_t;
  function automatic int ops(input int n);
    return 2 * n * n;
  endfunction
  function automatic int res(input int n);
    return n * n;
  endfunction
endpackage

// File: rtl/mm_host_buf.sv
// mm_host_buf: single-clock byte RAM, one write port and one asynchronous read port.
module mm_host_buf #(
  parameter int DW = 8,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mm_host.sv
// mm_host: host-side sequencer that loads A/B operands, streams them to a multiplier and drains C.
// Optional watchdog on the done wait is enabled by defining MM_HOST_TIMEOUT_EN.
module mm_host
  import mm_host_pkg::*;
#(
  parameter int DW = 8,
  parameter int N = 4,
  parameter int TO_CYC = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          acc_start,
  output logic [DW-1:0] acc_data_in,
  input  logic [DW-1:0] acc_data_out,
  input  logic          acc_done,
  output logic          busy,
  output logic          err
);
  localparam int OPS = ops(N);
  localparam int RES = res(N);
  localparam int AW = $clog2(OPS);
  localparam int CW = AW + 1;
  state_t state, state_d;
  logic [CW-1:0] idx, idx_d;
  logic [DW-1:0] op_rd;
  logic last, adv, to;
  // One index serves every phase; its terminal value depends on whether operands or results are walked.
  assign last = idx == ((state == LOAD || state == SEND) ? CW'(OPS - 1) : CW'(RES - 1));
  assign in_ready = state == LOAD;
  assign busy = state != LOAD;
  assign acc_start = state == START;
  assign acc_data_in = state == SEND ? op_rd : '0;
  assign out_valid = state == DRAIN;
  mm_host_buf #(.DW(DW), .DEPTH(OPS)) u_op (
    .clk(clk), .we(state == LOAD && in_valid), .waddr(idx[AW-1:0]), .wdata(in_data),
    .raddr(idx[AW-1:0]), .rdata(op_rd)
  );
  mm_host_buf #(.DW(DW), .DEPTH(OPS)) u_res (
    .clk(clk), .we(state == CAPT), .waddr(idx[AW-1:0]), .wdata(acc_data_out),
    .raddr(idx[AW-1:0]), .rdata(out_data)
  );
  always_comb begin
    adv = (state == LOAD && in_valid) || state == SEND || state == CAPT || (state == DRAIN && out_ready);
    idx_d = adv ? (last ? '0 : idx + CW'(1)) : idx;
    state_d = state;
    case (state)
      LOAD:    state_d = adv && last ? START : LOAD;
      START:   state_d = SEND;
      SEND:    state_d = last ? WAIT : SEND;
      WAIT:    state_d = acc_done ? CAPT : (to ? LOAD : WAIT);
      CAPT:    state_d = last ? DRAIN : CAPT;
      DRAIN:   state_d = adv && last ? LOAD : DRAIN;
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= LOAD;
      idx <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
    end
`ifdef MM_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] wd;
  logic err_q;
  assign to = state == WAIT && !acc_done && wd == TW'(TO_CYC - 1);
  assign err = err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wd <= '0;
      err_q <= 1'b0;
    end else begin
      wd <= state == WAIT ? wd + TW'(1) : '0;
      if (to) err_q <= 1'b1;
    end
`else
  assign to = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mm_host.sv
// tb_mm_host: directed table-driven bench for mm_host with N=2, plus stall, reset and watchdog sequences.
module tb_mm_host;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic acc_done = 1'b0;
  logic [7:0] acc_data_out = '0;
  logic in_ready, out_valid, acc_start, busy, err;
  logic [7:0] out_data, acc_data_in;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic iv; logic [7:0] id; logic ordy; logic dn; logic [7:0] ado;
    logic e_ir; logic e_st; logic [7:0] e_adi; logic e_ov; logic [7:0] e_od; logic e_busy;
  } vec_t;
  vec_t tv[28];
  logic [7:0] r[4];
  mm_host #(.DW(8), .N(2), .TO_CYC(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .acc_start(acc_start),
    .acc_data_in(acc_data_in), .acc_data_out(acc_data_out), .acc_done(acc_done), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy, input logic dn,
                              input logic [7:0] ado, input logic e_ir, input logic e_st,
                              input logic [7:0] e_adi, input logic e_ov, input logic [7:0] e_od,
                              input logic e_busy);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.dn = dn; v.ado = ado;
    v.e_ir = e_ir; v.e_st = e_st; v.e_adi = e_adi; v.e_ov = e_ov; v.e_od = e_od; v.e_busy = e_busy;
    return v;
  endfunction
  task automatic load(input int base);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 8'(base + i);
      tick();
    end
    in_valid = 1'b0;
    chk("load_start_pulse", acc_start, 1);
    chk("load_ready_low", in_ready, 0);
    tick();
  endtask
  task automatic send_chk(input int base);
    for (int k = 0; k < 8; k++) begin
      chk("send_operand", acc_data_in, 8'(base + k));
      tick();
    end
    chk("wait_data_zero", acc_data_in, 0);
  endtask
  task automatic finish_acc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] q[4];
    q[0] = a; q[1] = b; q[2] = c; q[3] = d;
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    for (int j = 0; j < 4; j++) begin
      acc_data_out = q[j];
      chk("capt_no_valid", out_valid, 0);
      tick();
    end
    acc_data_out = '0;
  endtask
  initial begin
    r[0] = 8'd19; r[1] = 8'd22; r[2] = 8'd43; r[3] = 8'd50;
    for (int i = 0; i < 8; i++) tv[i] = mk(1, 8'(i + 1), 0, i == 3, 0, 1, 0, 0, 0, 0, 0);
    tv[8] = mk(1, 8'd99, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) tv[9 + k] = mk(0, 0, 0, k == 3, 0, 0, 0, 8'(k + 1), 0, 0, 1);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tv[18] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 4; j++) tv[19 + j] = mk(0, 0, 0, 0, r[j], 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 4; j++) tv[23 + j] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, r[j], 1);
    tv[27] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset_acc_data_in", acc_data_in, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_acc_start", acc_start, 0);
    chk("reset_err", err, 0);
    for (int i = 0; i < 28; i++) begin
      in_valid = tv[i].iv; in_data = tv[i].id; out_ready = tv[i].ordy;
      acc_done = tv[i].dn; acc_data_out = tv[i].ado;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tv[i].e_ir);
      chk($sformatf("vec%0d_acc_start", i), acc_start, tv[i].e_st);
      chk($sformatf("vec%0d_acc_data_in", i), acc_data_in, tv[i].e_adi);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tv[i].e_ov);
      if (tv[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data, tv[i].e_od);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].e_busy);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; acc_done = 1'b0; acc_data_out = '0;
    chk("table_err", err, 0);
    begin
      logic [7:0] ex[6];
      logic rdy[6];
      ex = '{8'd5, 8'd6, 8'd6, 8'd6, 8'd7, 8'd8};
      rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      load(10);
      send_chk(10);
      finish_acc(5, 6, 7, 8);
      for (int c = 0; c < 6; c++) begin
        out_ready = rdy[c];
        #1;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, ex[c]);
        tick();
      end
      out_ready = 1'b0;
      chk("stall_back_to_load", in_ready, 1);
      chk("stall_busy_low", busy, 0);
    end
    load(30);
    tick();
    tick();
    chk("mid_send_operand", acc_data_in, 32);
    reset = 1'b1;
    #1;
    chk("mid_reset_acc_data_in", acc_data_in, 0);
    chk("mid_reset_in_ready", in_ready, 1);
    chk("mid_reset_busy", busy, 0);
    tick();
    reset = 1'b0;
    load(40);
    send_chk(40);
    finish_acc(1, 2, 3, 4);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("post_reset_out_data", out_data, 8'(j + 1));
      chk("post_reset_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b0;
    chk("post_reset_in_ready", in_ready, 1);
    load(50);
    send_chk(50);
    for (int c = 0; c < 15; c++) tick();
    chk("wd_err_before_limit", err, 0);
    chk("wd_busy_before_limit", busy, 1);
    tick();
`ifdef MM_HOST_TIMEOUT_EN
    chk("wd_err_set", err, 1);
    chk("wd_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) tick();
    chk("wd_err_sticky", err, 1);
`else
    for (int c = 0; c < 4; c++) tick();
    chk("nowd_err_zero", err, 0);
    chk("nowd_still_wait", in_ready, 0);
    chk("nowd_busy", busy, 1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("final_reset_err", err, 0);
    chk("final_reset_in_ready", in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
